// File: rtl/cpu_pkg.sv
// Shared definitions for the execute-stage control slice:
// condition codes, NZCV flag bit indices and common field widths.
package cpu_pkg;

   localparam int ALUCTL_W = 3;
   localparam int RA_W     = 4;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator.
// Ports: CondE (condition field), Flags ({N,Z,C,V}) -> CondPass.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] CondE,
   input  logic [3:0] Flags,
   output logic       CondPass
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   always_comb begin
      CondPass = 1'b0;
      unique case (CondE)
         COND_EQ: CondPass = z;
         COND_NE: CondPass = ~z;
         COND_CS: CondPass = c;
         COND_CC: CondPass = ~c;
         COND_MI: CondPass = n;
         COND_PL: CondPass = ~n;
         COND_VS: CondPass = v;
         COND_VC: CondPass = ~v;
         COND_HI: CondPass = c & ~z;
         COND_LS: CondPass = ~c | z;
         COND_GE: CondPass = (n == v);
         COND_LT: CondPass = (n != v);
         COND_GT: CondPass = ~z & (n == v);
         COND_LE: CondPass = z | (n != v);
         COND_AL: CondPass = 1'b1;
         COND_NV: CondPass = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_ex_stage.sv
// Execute-stage control: D->E control register, NZCV flag register,
// condition gating of register/memory/PC/flag writes.
// Inputs: clk, reset, StallE, FlushE, decoder D-stage controls, ALUFlagsE.
// Outputs: registered E controls, gated writes, FlagsE, and SquashCntE
// when COND_SQUASH_CNT_EN is defined (count of condition-failed slots).
module cond_ex_stage
   import cpu_pkg::*;
#(
   parameter int COND_W   = 4,
   parameter int ALUCTL_W = cpu_pkg::ALUCTL_W,
   parameter int RA_W     = cpu_pkg::RA_W,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                StallE,
   input  logic                FlushE,
   input  logic                ValidD,
   input  logic [COND_W-1:0]   CondD,
   input  logic                PCSD,
   input  logic                RegWD,
   input  logic                MemWD,
   input  logic                MemtoRegD,
   input  logic                ALUSrcD,
   input  logic                BranchD,
   input  logic                NoWriteD,
   input  logic [1:0]          FlagWD,
   input  logic [ALUCTL_W-1:0] ALUControlD,
   input  logic [RA_W-1:0]     WA3D,
   input  logic [3:0]          ALUFlagsE,
   output logic [ALUCTL_W-1:0] ALUControlE,
   output logic                ALUSrcE,
   output logic                MemtoRegE,
   output logic [RA_W-1:0]     WA3E,
   output logic                CondExE,
   output logic                RegWriteE,
   output logic                MemWriteE,
   output logic                PCSrcE,
   output logic                BranchTakenE,
`ifdef COND_SQUASH_CNT_EN
   output logic [CNT_W-1:0]    SquashCntE,
`endif
   output logic [3:0]          FlagsE
);

   typedef struct packed {
      logic                valid;
      logic [COND_W-1:0]   cond;
      logic                pcs;
      logic                regw;
      logic                memw;
      logic                mtr;
      logic                alusrc;
      logic                br;
      logic                nw;
      logic [1:0]          fw;
      logic [ALUCTL_W-1:0] aluctl;
      logic [RA_W-1:0]     wa3;
   } e_t;

   localparam e_t BUBBLE = '{cond: COND_W'(COND_AL), default: '0};

   e_t         e_q, e_d, d_in;
   logic [3:0] flags_q, flags_d;
   logic       pass;

   assign d_in = '{
      valid:  ValidD,
      cond:   CondD,
      pcs:    PCSD,
      regw:   RegWD,
      memw:   MemWD,
      mtr:    MemtoRegD,
      alusrc: ALUSrcD,
      br:     BranchD,
      nw:     NoWriteD,
      fw:     FlagWD,
      aluctl: ALUControlD,
      wa3:    WA3D
   };

   always_comb begin
      e_d = e_q;
      if (FlushE)
         e_d = BUBBLE;
      else if (!StallE)
         e_d = d_in;
   end

   cond_check u_cond_check (
      .CondE    (e_q.cond[3:0]),
      .Flags    (flags_q),
      .CondPass (pass)
   );

   assign CondExE      = pass & e_q.valid;
   assign RegWriteE    = e_q.regw & CondExE & ~e_q.nw;
   assign MemWriteE    = e_q.memw & CondExE;
   assign PCSrcE       = e_q.pcs & CondExE;
   assign BranchTakenE = e_q.br & CondExE;
   assign ALUControlE  = e_q.aluctl;
   assign ALUSrcE      = e_q.alusrc;
   assign MemtoRegE    = e_q.mtr;
   assign WA3E         = e_q.wa3;
   assign FlagsE       = flags_q;

   // Gating by ~StallE keeps a held instruction from writing flags
   // more than once; it writes only on its release edge.
   always_comb begin
      flags_d = flags_q;
      if (!StallE && CondExE) begin
         if (e_q.fw[1]) begin
            flags_d[FLAG_N] = ALUFlagsE[FLAG_N];
            flags_d[FLAG_Z] = ALUFlagsE[FLAG_Z];
         end
         if (e_q.fw[0]) begin
            flags_d[FLAG_C] = ALUFlagsE[FLAG_C];
            flags_d[FLAG_V] = ALUFlagsE[FLAG_V];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q     <= BUBBLE;
         flags_q <= '0;
      end else begin
         e_q     <= e_d;
         flags_q <= flags_d;
      end
   end

`ifdef COND_SQUASH_CNT_EN
   logic [CNT_W-1:0] sq_q, sq_d;
   logic             sq_inc;

   assign sq_inc = e_q.valid & ~CondExE & ~StallE & ~FlushE;

   always_comb begin
      sq_d = sq_q;
      if (sq_inc && (sq_q != '1))
         sq_d = sq_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         sq_q <= '0;
      else
         sq_q <= sq_d;
   end

   assign SquashCntE = sq_q;
`endif

endmodule
